// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags to issued instructions, captures
// common-data-bus results, forwards operands and retires in program order.
// Tag 0 means "no producer", so pointers cycle through 1..2^ROBWidth-1.
//
// Opcode encoding shared with the dispatcher:
//   0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4..9 BEQ..BGEU, 10..14 loads,
//   15..17 SB/SH/SW, 18..36 integer ALU ops, above 36 no register write.
module reorder_buffer #(
    parameter int ROBWidth      = 4,
    parameter int InstTypeWidth = 6,
    parameter int RegWidth      = 5,
    parameter int AddressWidth  = 32,
    parameter int IDWidth       = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     dispatcher_rob_en_in,
    input  logic [InstTypeWidth-1:0] dispatcher_rob_opcode_in,
    input  logic [RegWidth-1:0]      dispatcher_rob_dest_in,
    input  logic [AddressWidth-1:0]  dispatcher_rob_pc_in,
    input  logic                     dispatcher_rob_taken_in,
    output logic [ROBWidth-1:0]      rob_dispatcher_b_out,
    output logic                     rob_full_out,
    input  logic [ROBWidth-1:0]      dispatcher_rob_rs_h_in,
    input  logic [ROBWidth-1:0]      dispatcher_rob_rt_h_in,
    output logic                     rob_dispatcher_rs_ready_out,
    output logic                     rob_dispatcher_rt_ready_out,
    output logic [IDWidth-1:0]       rob_dispatcher_rs_value_out,
    output logic [IDWidth-1:0]       rob_dispatcher_rt_value_out,
    input  logic                     cdb_en_in,
    input  logic [ROBWidth-1:0]      cdb_tag_in,
    input  logic [IDWidth-1:0]       cdb_value_in,
    input  logic                     cdb_taken_in,
    input  logic [AddressWidth-1:0]  cdb_target_in,
    output logic                     rob_regfile_en_out,
    output logic [RegWidth-1:0]      rob_regfile_rd_out,
    output logic [IDWidth-1:0]       rob_regfile_value_out,
    output logic [ROBWidth-1:0]      rob_regfile_tag_out,
    output logic                     rob_lsb_store_en_out,
    output logic [ROBWidth-1:0]      rob_lsb_store_tag_out,
    output logic                     rob_bp_en_out,
    output logic [AddressWidth-1:0]  rob_bp_pc_out,
    output logic                     rob_bp_taken_out,
    output logic                     rob_flush_out,
    output logic [AddressWidth-1:0]  rob_flush_pc_out
);

    localparam int Entries = 1 << ROBWidth;

    localparam logic [ROBWidth-1:0]      TagZero  = ROBWidth'(0);
    localparam logic [ROBWidth-1:0]      TagFirst = ROBWidth'(1);
    localparam logic [ROBWidth-1:0]      TagLast  = {ROBWidth{1'b1}};
    localparam logic [Entries-1:0]       MaskZero = {Entries{1'b0}};
    localparam logic [Entries-1:0]       MaskOne  = Entries'(1);
    localparam logic [RegWidth-1:0]      RegZero  = {RegWidth{1'b0}};
    localparam logic [IDWidth-1:0]       ValZero  = {IDWidth{1'b0}};
    localparam logic [AddressWidth-1:0]  AddrZero = {AddressWidth{1'b0}};
    localparam logic [InstTypeWidth-1:0] OpZero   = {InstTypeWidth{1'b0}};

    localparam logic [InstTypeWidth-1:0] OpJal     = InstTypeWidth'(2);
    localparam logic [InstTypeWidth-1:0] OpJalr    = InstTypeWidth'(3);
    localparam logic [InstTypeWidth-1:0] OpBeq     = InstTypeWidth'(4);
    localparam logic [InstTypeWidth-1:0] OpBgeu    = InstTypeWidth'(9);
    localparam logic [InstTypeWidth-1:0] OpSb      = InstTypeWidth'(15);
    localparam logic [InstTypeWidth-1:0] OpSw      = InstTypeWidth'(17);
    localparam logic [InstTypeWidth-1:0] OpAluLast = InstTypeWidth'(36);

    // Conditional branches BEQ..BGEU
    function automatic logic op_is_branch(input logic [InstTypeWidth-1:0] op);
        return (op >= OpBeq) && (op <= OpBgeu);
    endfunction

    // Stores SB/SH/SW
    function automatic logic op_is_store(input logic [InstTypeWidth-1:0] op);
        return (op >= OpSb) && (op <= OpSw);
    endfunction

    // Everything up to the last ALU op writes rd, except branches and stores
    function automatic logic op_writes_rd(input logic [InstTypeWidth-1:0] op);
        return (op <= OpAluLast) && !op_is_branch(op) && !op_is_store(op);
    endfunction

    // Pointer increment that skips tag 0 on wrap
    function automatic logic [ROBWidth-1:0] next_tag(input logic [ROBWidth-1:0] t);
        return (t == TagLast) ? TagFirst : (t + TagFirst);
    endfunction

    // Control state
    logic [ROBWidth-1:0] head_q, head_d;
    logic [ROBWidth-1:0] tail_q, tail_d;
    logic [ROBWidth-1:0] count_q, count_d;
    logic [Entries-1:0]  valid_q, valid_d;
    logic [Entries-1:0]  ready_q, ready_d;

    // Entry payload
    logic [InstTypeWidth-1:0] opcode_q [Entries];
    logic [RegWidth-1:0]      dest_q   [Entries];
    logic [AddressWidth-1:0]  pc_q     [Entries];
    logic                     pred_q   [Entries];
    logic [IDWidth-1:0]       value_q  [Entries];
    logic                     taken_q  [Entries];
    logic [AddressWidth-1:0]  target_q [Entries];

    // Registered commit outputs
    logic                    rf_en_q, rf_en_d;
    logic [RegWidth-1:0]     rf_rd_q, rf_rd_d;
    logic [IDWidth-1:0]      rf_val_q, rf_val_d;
    logic [ROBWidth-1:0]     rf_tag_q, rf_tag_d;
    logic                    st_en_q, st_en_d;
    logic [ROBWidth-1:0]     st_tag_q, st_tag_d;
    logic                    bp_en_q, bp_en_d;
    logic [AddressWidth-1:0] bp_pc_q, bp_pc_d;
    logic                    bp_taken_q, bp_taken_d;
    logic                    fl_en_q, fl_en_d;
    logic [AddressWidth-1:0] fl_pc_q, fl_pc_d;

    // Per-cycle events
    logic                     full_s;
    logic                     alloc_s;
    logic                     wb_s;
    logic                     commit_s;
    logic                     flush_s;
    logic [InstTypeWidth-1:0] head_op_s;
    logic                     head_branch_s;
    logic                     head_mispredict_s;
    logic [Entries-1:0]       alloc_mask_s;
    logic [Entries-1:0]       wb_mask_s;
    logic [Entries-1:0]       commit_mask_s;
    logic                     rs_fwd_s;
    logic                     rt_fwd_s;

    // Event decode: what allocates, writes back, commits and flushes this cycle
    always_comb begin
        full_s            = (count_q == TagLast);
        alloc_s           = rdy_in && dispatcher_rob_en_in && !full_s;
        wb_s              = rdy_in && cdb_en_in && (cdb_tag_in != TagZero) && valid_q[cdb_tag_in];
        commit_s          = rdy_in && valid_q[head_q] && ready_q[head_q];
        head_op_s         = opcode_q[head_q];
        head_branch_s     = op_is_branch(head_op_s);
        head_mispredict_s = head_branch_s && (taken_q[head_q] != pred_q[head_q]);
        flush_s           = commit_s && (head_mispredict_s || (head_op_s == OpJalr));
        alloc_mask_s      = alloc_s ? (MaskOne << tail_q) : MaskZero;
        wb_mask_s         = wb_s ? (MaskOne << cdb_tag_in) : MaskZero;
        commit_mask_s     = commit_s ? (MaskOne << head_q) : MaskZero;
    end

    // Next-state for pointers, occupancy and entry valid/ready flags
    always_comb begin
        valid_d = flush_s ? MaskZero : ((valid_q | alloc_mask_s) & ~commit_mask_s);
        ready_d = flush_s ? MaskZero
                          : ((ready_q | wb_mask_s) & ~alloc_mask_s & ~commit_mask_s);
        head_d  = flush_s ? TagFirst : (commit_s ? next_tag(head_q) : head_q);
        tail_d  = flush_s ? TagFirst : (alloc_s ? next_tag(tail_q) : tail_q);
        case ({flush_s, alloc_s, commit_s})
            3'b010:  count_d = count_q + TagFirst;
            3'b001:  count_d = count_q - TagFirst;
            3'b100, 3'b101, 3'b110, 3'b111: count_d = TagZero;
            default: count_d = count_q;
        endcase
    end

    // Commit outputs derived from the head entry; zero when nothing retires
    always_comb begin
        rf_en_d    = commit_s && op_writes_rd(head_op_s) && (dest_q[head_q] != RegZero);
        rf_rd_d    = rf_en_d ? dest_q[head_q] : RegZero;
        rf_val_d   = rf_en_d ? value_q[head_q] : ValZero;
        rf_tag_d   = rf_en_d ? head_q : TagZero;
        st_en_d    = commit_s && op_is_store(head_op_s);
        st_tag_d   = st_en_d ? head_q : TagZero;
        bp_en_d    = commit_s && head_branch_s;
        bp_pc_d    = bp_en_d ? pc_q[head_q] : AddrZero;
        bp_taken_d = bp_en_d && taken_q[head_q];
        fl_en_d    = flush_s;
        fl_pc_d    = flush_s ? target_q[head_q] : AddrZero;
    end

    // Control state register; rdy_in low leaves every _d equal to _q
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= TagFirst;
            tail_q  <= TagFirst;
            count_q <= TagZero;
            valid_q <= MaskZero;
            ready_q <= MaskZero;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Entry payload: fields written on allocate, results written on broadcast
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < Entries; i++) begin
                opcode_q[i] <= OpZero;
                dest_q[i]   <= RegZero;
                pc_q[i]     <= AddrZero;
                pred_q[i]   <= 1'b0;
                value_q[i]  <= ValZero;
                taken_q[i]  <= 1'b0;
                target_q[i] <= AddrZero;
            end
        end else begin
            if (alloc_s && !flush_s) begin
                opcode_q[tail_q] <= dispatcher_rob_opcode_in;
                dest_q[tail_q]   <= dispatcher_rob_dest_in;
                pc_q[tail_q]     <= dispatcher_rob_pc_in;
                pred_q[tail_q]   <= dispatcher_rob_taken_in;
            end
            if (wb_s && !flush_s) begin
                value_q[cdb_tag_in]  <= cdb_value_in;
                taken_q[cdb_tag_in]  <= cdb_taken_in;
                target_q[cdb_tag_in] <= cdb_target_in;
            end
        end
    end

    // Commit/flush pulse registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rf_en_q    <= 1'b0;
            rf_rd_q    <= RegZero;
            rf_val_q   <= ValZero;
            rf_tag_q   <= TagZero;
            st_en_q    <= 1'b0;
            st_tag_q   <= TagZero;
            bp_en_q    <= 1'b0;
            bp_pc_q    <= AddrZero;
            bp_taken_q <= 1'b0;
            fl_en_q    <= 1'b0;
            fl_pc_q    <= AddrZero;
        end else begin
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_val_q   <= rf_val_d;
            rf_tag_q   <= rf_tag_d;
            st_en_q    <= st_en_d;
            st_tag_q   <= st_tag_d;
            bp_en_q    <= bp_en_d;
            bp_pc_q    <= bp_pc_d;
            bp_taken_q <= bp_taken_d;
            fl_en_q    <= fl_en_d;
            fl_pc_q    <= fl_pc_d;
        end
    end

    // Operand query with same-cycle bypass from the broadcast bus
    always_comb begin
        rs_fwd_s = cdb_en_in && (cdb_tag_in == dispatcher_rob_rs_h_in);
        rt_fwd_s = cdb_en_in && (cdb_tag_in == dispatcher_rob_rt_h_in);
        rob_dispatcher_rs_ready_out = (dispatcher_rob_rs_h_in != TagZero) &&
            ((valid_q[dispatcher_rob_rs_h_in] && ready_q[dispatcher_rob_rs_h_in]) || rs_fwd_s);
        rob_dispatcher_rt_ready_out = (dispatcher_rob_rt_h_in != TagZero) &&
            ((valid_q[dispatcher_rob_rt_h_in] && ready_q[dispatcher_rob_rt_h_in]) || rt_fwd_s);
        rob_dispatcher_rs_value_out = rs_fwd_s ? cdb_value_in : value_q[dispatcher_rob_rs_h_in];
        rob_dispatcher_rt_value_out = rt_fwd_s ? cdb_value_in : value_q[dispatcher_rob_rt_h_in];
    end

    assign rob_dispatcher_b_out  = tail_q;
    assign rob_full_out          = full_s;
    assign rob_regfile_en_out    = rf_en_q;
    assign rob_regfile_rd_out    = rf_rd_q;
    assign rob_regfile_value_out = rf_val_q;
    assign rob_regfile_tag_out   = rf_tag_q;
    assign rob_lsb_store_en_out  = st_en_q;
    assign rob_lsb_store_tag_out = st_tag_q;
    assign rob_bp_en_out         = bp_en_q;
    assign rob_bp_pc_out         = bp_pc_q;
    assign rob_bp_taken_out      = bp_taken_q;
    assign rob_flush_out         = fl_en_q;
    assign rob_flush_pc_out      = fl_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised bench for reorder_buffer against an in-order queue model, with a
// scoreboard of expected commit pulses checked by an independent monitor.
module tb_reorder_buffer;

    localparam logic [5:0] OP_JAL  = 6'd2;
    localparam logic [5:0] OP_JALR = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd17;
    localparam logic [5:0] OP_ADD  = 6'd27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, rdy = 1'b1;
    logic        d_en = 1'b0, d_pred = 1'b0;
    logic [5:0]  d_op = 6'd0;
    logic [4:0]  d_rd = 5'd0;
    logic [31:0] d_pc = 32'd0;
    logic [3:0]  q_rs = 4'd0, q_rt = 4'd0;
    logic        c_en = 1'b0, c_taken = 1'b0;
    logic [3:0]  c_tag = 4'd0;
    logic [31:0] c_val = 32'd0, c_tgt = 32'd0;

    logic [3:0]  b_out;
    logic        full, rs_ready, rt_ready;
    logic [31:0] rs_value, rt_value;
    logic        rf_en, st_en, bp_en, bp_taken, fl_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_val, bp_pc, fl_pc;
    logic [3:0]  rf_tag, st_tag;

    reorder_buffer dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .dispatcher_rob_en_in(d_en), .dispatcher_rob_opcode_in(d_op),
        .dispatcher_rob_dest_in(d_rd), .dispatcher_rob_pc_in(d_pc),
        .dispatcher_rob_taken_in(d_pred), .rob_dispatcher_b_out(b_out),
        .rob_full_out(full), .dispatcher_rob_rs_h_in(q_rs), .dispatcher_rob_rt_h_in(q_rt),
        .rob_dispatcher_rs_ready_out(rs_ready), .rob_dispatcher_rt_ready_out(rt_ready),
        .rob_dispatcher_rs_value_out(rs_value), .rob_dispatcher_rt_value_out(rt_value),
        .cdb_en_in(c_en), .cdb_tag_in(c_tag), .cdb_value_in(c_val),
        .cdb_taken_in(c_taken), .cdb_target_in(c_tgt),
        .rob_regfile_en_out(rf_en), .rob_regfile_rd_out(rf_rd),
        .rob_regfile_value_out(rf_val), .rob_regfile_tag_out(rf_tag),
        .rob_lsb_store_en_out(st_en), .rob_lsb_store_tag_out(st_tag),
        .rob_bp_en_out(bp_en), .rob_bp_pc_out(bp_pc), .rob_bp_taken_out(bp_taken),
        .rob_flush_out(fl_en), .rob_flush_pc_out(fl_pc)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        done;
        logic [31:0] val;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    typedef struct packed {
        int          cyc;
        logic        rf_en;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  rtag;
        logic        st_en;
        logic [3:0]  st_tag;
        logic        bp_en;
        logic [31:0] bp_pc;
        logic        bp_tk;
        logic        fl_en;
        logic [31:0] fl_pc;
    } exp_t;

    ent_t       mq[$];
    exp_t       eq[$];
    exp_t       mon_e;
    logic [3:0] m_tail = 4'd1;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         pct = 50;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every visible commit pulse must match the oldest expectation
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].cyc < cyc) begin
            mon_e = eq.pop_front();
            checks++;
            errors++;
            $display("FAIL commit_missing: expected pulse at cycle %0d not seen", mon_e.cyc);
        end
        if (rf_en || st_en || bp_en || fl_en) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: rf=%b st=%b bp=%b fl=%b at cycle %0d",
                         rf_en, st_en, bp_en, fl_en, cyc);
            end else begin
                mon_e = eq.pop_front();
                if (mon_e.cyc != cyc || rf_en !== mon_e.rf_en || rf_rd !== mon_e.rd ||
                    rf_val !== mon_e.val || rf_tag !== mon_e.rtag || st_en !== mon_e.st_en ||
                    st_tag !== mon_e.st_tag || bp_en !== mon_e.bp_en || bp_pc !== mon_e.bp_pc ||
                    bp_taken !== mon_e.bp_tk || fl_en !== mon_e.fl_en || fl_pc !== mon_e.fl_pc) begin
                    errors++;
                    $display("FAIL commit_out: cyc %0d got rf=%b/%0d/%0h/%0d st=%b/%0d bp=%b/%0h/%b fl=%b/%0h expected cyc %0d rf=%b/%0d/%0h/%0d st=%b/%0d bp=%b/%0h/%b fl=%b/%0h",
                             cyc, rf_en, rf_rd, rf_val, rf_tag, st_en, st_tag, bp_en, bp_pc, bp_taken, fl_en, fl_pc,
                             mon_e.cyc, mon_e.rf_en, mon_e.rd, mon_e.val, mon_e.rtag, mon_e.st_en, mon_e.st_tag,
                             mon_e.bp_en, mon_e.bp_pc, mon_e.bp_tk, mon_e.fl_en, mon_e.fl_pc);
                end
            end
        end else begin
            chk("idle_outputs_zero", 64'(|{rf_rd, rf_val, rf_tag, st_tag, bp_pc, bp_taken, fl_pc}), 64'd0);
        end
    end

    // Expected query answer from the in-flight program-order list
    task automatic qexp(input logic [3:0] t, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = 32'd0;
        if (t != 4'd0) begin
            if (c_en && c_tag == t) begin
                r = 1'b1;
                v = c_val;
            end else begin
                foreach (mq[i]) if (mq[i].tag == t && mq[i].done) begin
                    r = 1'b1;
                    v = mq[i].val;
                end
            end
        end
    endtask

    // One clock: check queries, advance the model across the edge, check tail/full
    task automatic tick();
        ent_t n;
        exp_t e;
        logic er, commit, flush, full_pre, is_br, is_st, wr;
        logic [31:0] ev;
        #1;
        qexp(q_rs, er, ev);
        chk("q_rs_ready", 64'(rs_ready), 64'(er));
        if (er) chk("q_rs_value", 64'(rs_value), 64'(ev));
        qexp(q_rt, er, ev);
        chk("q_rt_ready", 64'(rt_ready), 64'(er));
        if (er) chk("q_rt_value", 64'(rt_value), 64'(ev));
        if (!rst_n) begin
            mq.delete();
            m_tail = 4'd1;
        end else if (rdy) begin
            full_pre = (mq.size() == 15);
            commit   = (mq.size() > 0) && mq[0].done;
            flush    = 1'b0;
            if (commit) begin
                n     = mq[0];
                e     = '0;
                e.cyc = cyc + 1;
                is_br = n.op inside {[6'd4:6'd9]};
                is_st = n.op inside {[6'd15:6'd17]};
                wr    = n.op inside {[6'd0:6'd3], [6'd10:6'd14], [6'd18:6'd36]};
                if (wr && n.rd != 5'd0) begin
                    e.rf_en = 1'b1; e.rd = n.rd; e.val = n.val; e.rtag = n.tag;
                end
                if (is_st) begin
                    e.st_en = 1'b1; e.st_tag = n.tag;
                end
                if (is_br) begin
                    e.bp_en = 1'b1; e.bp_pc = n.pc; e.bp_tk = n.tk;
                end
                if ((is_br && n.tk != n.pred) || n.op == OP_JALR) begin
                    e.fl_en = 1'b1; e.fl_pc = n.tgt; flush = 1'b1;
                end
                if (e.rf_en || e.st_en || e.bp_en || e.fl_en) eq.push_back(e);
            end
            if (flush) begin
                mq.delete();
                m_tail = 4'd1;
            end else begin
                if (c_en) foreach (mq[i]) if (mq[i].tag == c_tag) begin
                    mq[i].done = 1'b1; mq[i].val = c_val; mq[i].tk = c_taken; mq[i].tgt = c_tgt;
                end
                if (commit) void'(mq.pop_front());
                if (d_en && !full_pre) begin
                    n = '0;
                    n.tag = m_tail; n.op = d_op; n.rd = d_rd; n.pc = d_pc; n.pred = d_pred;
                    mq.push_back(n);
                    m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
                end
            end
        end
        @(negedge clk);
        chk("tail_tag", 64'(b_out), 64'(m_tail));
        chk("full_flag", 64'(full), 64'(mq.size() == 15));
    endtask

    task automatic set_idle();
        rst_n = 1'b1; rdy = 1'b1; d_en = 1'b0; c_en = 1'b0; q_rs = 4'd0; q_rt = 4'd0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        set_idle();
        d_en = 1'b1; d_op = op; d_rd = rd; d_pc = pc; d_pred = pred;
        tick();
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        set_idle();
        c_en = 1'b1; c_tag = tag; c_val = val; c_taken = tk; c_tgt = tgt;
        tick();
    endtask

    task automatic idle_tick();
        set_idle();
        tick();
    endtask

    initial begin
        @(negedge clk);
        // Reset and three allocations, then out-of-order completion
        do_reset();
        chk("reset_tail", 64'(b_out), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            chk("alloc_tag", 64'(b_out), 64'(k));
            alloc(OP_ADD, 5'(k), 32'((k - 1) * 4), 1'b0);
        end
        chk("after3_tail", 64'(b_out), 64'd4);
        bcast(4'd2, 32'd7, 1'b0, 32'd0);
        bcast(4'd1, 32'd5, 1'b0, 32'd0);
        idle_tick();
        chk("commit1", {rf_en, 3'b0, rf_rd, rf_val, rf_tag}, {1'b1, 3'b0, 5'd1, 32'd5, 4'd1});
        idle_tick();
        chk("commit2", {rf_en, 3'b0, rf_rd, rf_val, rf_tag}, {1'b1, 3'b0, 5'd2, 32'd7, 4'd2});
        bcast(4'd3, 32'd9, 1'b0, 32'd0);
        idle_tick();

        // Fill to 15, refused 16th, commit one and wrap to tag 1
        do_reset();
        for (int k = 1; k <= 15; k++) alloc(OP_SW, 5'd0, 32'(k * 4), 1'b0);
        chk("full_set", 64'(full), 64'd1);
        chk("full_tail_wrap", 64'(b_out), 64'd1);
        alloc(OP_ADD, 5'd9, 32'h100, 1'b0);
        chk("full_refused", 64'(b_out), 64'd1);
        bcast(4'd1, 32'd0, 1'b0, 32'd0);
        alloc(OP_ADD, 5'd9, 32'h104, 1'b0);
        chk("full_refused_during_commit", 64'(b_out), 64'd1);
        chk("store_commit", {st_en, st_tag}, {1'b1, 4'd1});
        chk("not_full", 64'(full), 64'd0);
        alloc(OP_ADD, 5'd9, 32'h108, 1'b0);
        chk("wrap_tail", 64'(b_out), 64'd2);

        // Mispredicted branch with two younger entries; flush drops same-cycle work
        do_reset();
        alloc(OP_BEQ, 5'd0, 32'h10, 1'b1);
        alloc(OP_ADD, 5'd4, 32'h14, 1'b0);
        alloc(OP_ADD, 5'd5, 32'h18, 1'b0);
        bcast(4'd1, 32'd0, 1'b0, 32'h14);
        set_idle();
        d_en = 1'b1; d_op = OP_ADD; d_rd = 5'd6; d_pc = 32'h1c;
        c_en = 1'b1; c_tag = 4'd2; c_val = 32'd3;
        tick();
        chk("mispredict_bp", {bp_en, bp_taken, bp_pc}, {1'b1, 1'b0, 32'h10});
        chk("mispredict_flush", {fl_en, fl_pc}, {1'b1, 32'h14});
        chk("flush_tail", 64'(b_out), 64'd1);
        chk("flush_full", 64'(full), 64'd0);

        // Forwarding query, tag-0 query, rdy_in freeze, commit to x0
        do_reset();
        alloc(OP_ADD, 5'd0, 32'h40, 1'b0);
        for (int k = 2; k <= 4; k++) alloc(OP_ADD, 5'd6, 32'(k * 4), 1'b0);
        set_idle();
        c_en = 1'b1; c_tag = 4'd4; c_val = 32'hdead; q_rs = 4'd4; q_rt = 4'd0;
        #1;
        chk("fwd_ready", 64'(rs_ready), 64'd1);
        chk("fwd_value", 64'(rs_value), 64'hdead);
        chk("tag0_ready", 64'(rt_ready), 64'd0);
        tick();
        bcast(4'd1, 32'd11, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_idle();
            rdy = 1'b0; d_en = 1'b1; d_op = OP_ADD; c_en = 1'b1; c_tag = 4'd2;
            tick();
            chk("rdy_low_hold", 64'(b_out), 64'd5);
        end
        idle_tick();
        chk("x0_no_write", 64'(rf_en), 64'd0);
        bcast(4'd2, 32'd22, 1'b0, 32'd0);
        chk("after_x0_next_commit", {rf_en, rf_tag}, {1'b0, 4'd0});
        idle_tick();
        chk("head_advanced", {rf_en, rf_tag, rf_val}, {1'b1, 4'd2, 32'd22});

        // Randomised traffic
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 0) pct = (pct == 20) ? 70 : 20;
            rst_n  = ($urandom % 600) != 0;
            rdy    = ($urandom % 10) != 0;
            d_en   = ($urandom % 3) != 0;
            case ($urandom % 20)
                0:       d_op = OP_JALR;
                1:       d_op = OP_BEQ + 6'($urandom % 6);
                2, 3:    d_op = 6'd15 + 6'($urandom % 3);
                4:       d_op = OP_JAL;
                default: d_op = 6'($urandom_range(0, 40));
            endcase
            d_rd    = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
            d_pc    = $urandom;
            d_pred  = 1'($urandom);
            c_en    = ($urandom % 100) < pct;
            c_tag   = (mq.size() > 0 && ($urandom % 4) != 0) ? mq[$urandom % mq.size()].tag : 4'($urandom);
            c_val   = $urandom;
            c_taken = 1'($urandom);
            c_tgt   = $urandom;
            q_rs    = (($urandom % 3) == 0) ? c_tag : 4'($urandom);
            q_rt    = 4'($urandom);
            tick();
        end
        idle_tick();
        idle_tick();
        chk("pending_commits", 64'(eq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
